mac_dot_seq: RTL and testbench

//  Sequencer that drives the single-cycle MAC ALU to compute a signed dot product sum(a[i]*b[i]), i=0..len-1.

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_dot_seq.sv | 116 +++++++++++
 tb/tb_mac_dot_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants and state type for the MAC dot-product sequencer.
// MAC ALU opcode/funct encodings and the sequencer FSM encoding.
package mac_pkg;

    localparam logic [2:0] MAC_OP_ACC     = 3'b100;
    localparam logic [2:0] MAC_OP_NOP     = 3'b000;
    localparam logic       MAC_FUNCT_LOAD = 1'b1;
    localparam logic       MAC_FUNCT_MAC  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACC,
        READOUT,
        HOLD
    } mac_seq_state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer driving an external single-cycle MAC ALU.
// Ports: start/a_base/b_base/len job request, rd_* operand buffer,
// mac_* ALU drive and readback, result/result_valid/result_ready out.
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int REG_DATA_WIDTH = 16,
    parameter int OPCODE_WIDTH   = 3,
    parameter int ADDR_WIDTH     = 8,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     a_base,
    input  logic [ADDR_WIDTH-1:0]     b_base,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic                      busy,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     rd_addr_a,
    output logic [ADDR_WIDTH-1:0]     rd_addr_b,
    input  logic [REG_DATA_WIDTH-1:0] rd_data_a,
    input  logic [REG_DATA_WIDTH-1:0] rd_data_b,
    output logic                      mac_funct,
    output logic [OPCODE_WIDTH-1:0]   mac_opcode,
    output logic [REG_DATA_WIDTH-1:0] mac_rs1,
    output logic [REG_DATA_WIDTH-1:0] mac_rs2,
    input  logic [REG_DATA_WIDTH-1:0] mac_rd,
    output logic [REG_DATA_WIDTH-1:0] result,
    output logic                      result_valid,
    input  logic                      result_ready
);

    mac_seq_state_t state, state_n;

    logic [ADDR_WIDTH-1:0]     a_base_q;
    logic [ADDR_WIDTH-1:0]     b_base_q;
    logic [LEN_WIDTH-1:0]      len_q;
    // Number of read strobes issued so far in this job.
    logic [LEN_WIDTH-1:0]      idx;
    logic [REG_DATA_WIDTH-1:0] result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_base_q <= '0;
            b_base_q <= '0;
            len_q    <= '0;
            idx      <= '0;
            result_q <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_base_q <= a_base;
                        b_base_q <= b_base;
                        len_q    <= len;
                        idx      <= '0;
                    end
                end
                CLEAR, ACC: begin
                    if (rd_en) idx <= idx + 1'b1;
                end
                READOUT: result_q <= mac_rd;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        rd_en      = 1'b0;
        mac_funct  = MAC_FUNCT_MAC;
        mac_opcode = OPCODE_WIDTH'(MAC_OP_NOP);
        mac_rs1    = '0;
        mac_rs2    = '0;
        unique case (state)
            IDLE: begin
                if (start) state_n = CLEAR;
            end
            CLEAR: begin
                mac_funct  = MAC_FUNCT_LOAD;
                mac_opcode = OPCODE_WIDTH'(MAC_OP_ACC);
                if (len_q != '0) begin
                    rd_en   = 1'b1;
                    state_n = ACC;
                end else begin
                    state_n = READOUT;
                end
            end
            ACC: begin
                mac_opcode = OPCODE_WIDTH'(MAC_OP_ACC);
                mac_rs1    = rd_data_a;
                mac_rs2    = rd_data_b;
                // idx reaching len means this cycle consumes the last pair.
                if (idx < len_q) rd_en = 1'b1;
                else             state_n = READOUT;
            end
            READOUT: state_n = HOLD;
            HOLD: begin
                if (result_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Addresses are zero whenever no read is requested.
    assign rd_addr_a = rd_en ? a_base_q + ADDR_WIDTH'(idx) : '0;
    assign rd_addr_b = rd_en ? b_base_q + ADDR_WIDTH'(idx) : '0;

    assign busy         = (state != IDLE);
    assign result_valid = (state == HOLD);
    assign result       = result_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq with an operand buffer
// and MAC ALU model; random and directed dot-product jobs.
module tb_mac_dot_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a_base = '0;
    logic [7:0]  b_base = '0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        rd_en;
    logic [7:0]  rd_addr_a;
    logic [7:0]  rd_addr_b;
    logic [15:0] rd_data_a = '0;
    logic [15:0] rd_data_b = '0;
    logic        mac_funct;
    logic [2:0]  mac_opcode;
    logic [15:0] mac_rs1;
    logic [15:0] mac_rs2;
    logic [15:0] mac_rd;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;

    mac_dot_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .a_base(a_base), .b_base(b_base), .len(len),
        .busy(busy), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .mac_funct(mac_funct), .mac_opcode(mac_opcode),
        .mac_rs1(mac_rs1), .mac_rs2(mac_rs2), .mac_rd(mac_rd),
        .result(result), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end
    end

    logic [15:0] psum = 16'h1234;
    always @(posedge clk) begin
        if (mac_opcode == 3'b100)
            psum <= mac_funct ? mac_rs2 : 16'(psum + mac_rs1 * mac_rs2);
    end
    assign mac_rd = (mac_opcode == 3'b000) ? psum : 16'h0BAD;

    typedef struct {
        logic [7:0]  abase;
        logic [7:0]  bbase;
        logic [7:0]  len;
        logic [15:0] exp;
        int          start_cyc;
    } job_t;

    job_t q[$];
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int  rd_cnt = 0;
    bit  was_valid = 0;

    always @(negedge clk) begin
        if (rst) begin
            rd_cnt    = 0;
            was_valid = 0;
        end else begin
            if (rd_en) begin
                if (q.size() > 0) begin
                    check("rd_addr_a", rd_addr_a, 8'(q[0].abase + 8'(rd_cnt)));
                    check("rd_addr_b", rd_addr_b, 8'(q[0].bbase + 8'(rd_cnt)));
                end
                rd_cnt++;
            end
            if (result_valid) begin
                check("rd_en_in_hold", rd_en, 0);
                check("busy_in_hold", busy, 1);
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    if (!was_valid) begin
                        check("latency", cyc - q[0].start_cyc, q[0].len + 3);
                        check("rd_strobes", rd_cnt, q[0].len);
                    end
                    check("result", result, q[0].exp);
                    if (result_ready) begin
                        void'(q.pop_front());
                        rd_cnt = 0;
                    end
                end
            end
            was_valid = result_valid && !result_ready;
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_addr_a", rd_addr_a, 0);
        check("rst_addr_b", rd_addr_b, 0);
        check("rst_funct", mac_funct, 0);
        check("rst_opcode", mac_opcode, 0);
        check("rst_rs1", mac_rs1, 0);
        check("rst_rs2", mac_rs2, 0);
    endtask

    // ready_pat: 0 = always ready, 1 = random, 2 = hold off 5 cycles and poke start
    task automatic do_job(input logic [7:0] ab, input logic [7:0] bb,
                          input logic [7:0] ln, input int ready_pat);
        job_t   j;
        longint s = 0;
        int     hc = 0;
        bit     done = 0;
        for (int i = 0; i < int'(ln); i++) begin
            logic [7:0] ai;
            logic [7:0] bi;
            ai = ab + 8'(i);
            bi = bb + 8'(i);
            s += longint'($signed(mem_a[ai])) * longint'($signed(mem_b[bi]));
        end
        j.abase = ab;
        j.bbase = bb;
        j.len = ln;
        j.exp = 16'(s);
        j.start_cyc = cyc;
        q.push_back(j);
        a_base = ab;
        b_base = bb;
        len = ln;
        result_ready = (ready_pat == 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_base = 8'($urandom);
        b_base = 8'($urandom);
        len = 8'($urandom);
        for (int k = 0; k < 2000; k++) begin
            if (ready_pat == 1) result_ready = 1'($urandom);
            if (ready_pat == 2) begin
                if (result_valid) hc++;
                result_ready = (hc >= 5);
                start = (hc == 2);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!busy) begin
                done = 1;
                break;
            end
        end
        check("job_done", done, 1);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 16'($urandom);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 16'(i + 1);
            mem_b[i] = 16'(i + 5);
        end
        do_job(8'h00, 8'h00, 8'd4, 0);
        do_job(8'h00, 8'h00, 8'd0, 0);

        mem_a[8'h20] = 16'hFFFD;
        mem_a[8'h21] = 16'd300;
        mem_b[8'h30] = 16'd7;
        mem_b[8'h31] = 16'd300;
        do_job(8'h20, 8'h30, 8'd2, 0);

        do_job(8'hFE, 8'h10, 8'd3, 1);

        do_job(8'h40, 8'h50, 8'd6, 2);
        do_job(8'h20, 8'h30, 8'd2, 0);

        a_base = 8'h00;
        b_base = 8'h00;
        len = 8'd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_a[8'h70] = 16'd2;
        mem_b[8'h80] = 16'd3;
        do_job(8'h70, 8'h80, 8'd1, 0);

        for (int t = 0; t < 25; t++) begin
            do_job(8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)), int'($urandom_range(0, 1)));
        end
        do_job(8'($urandom), 8'($urandom), 8'd255, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
